stim_resp_checker: RTL and testbench

STIM_RESP_CHECKER -- requirements
Module: stim_resp_checker

---
 rtl/stim_resp_checker.sv | 116 +++++++++++
 tb/tb_stim_resp_checker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stim_resp_checker.sv
// rtl/stim_resp_checker.sv - exhaustive 4-input stimulus sweep with golden f/g response checking
module stim_resp_checker #(
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] EXP_F       = 16'h0000,
    parameter logic [15:0] EXP_G       = 16'h0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_f,
    input  logic       dut_g,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_err_valid,
    output logic [3:0] first_err_vec
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] vec, vec_n;
    logic [7:0] hold_cnt, hold_cnt_n;
    logic [4:0] err_count_n;
    logic       first_err_valid_n;
    logic [3:0] first_err_vec_n;
    logic       busy_n, done_n, pass_n;
    logic       mismatch;

    assign {a, b, c, d} = vec;

    assign mismatch = (dut_f != EXP_F[vec]) || (dut_g != EXP_G[vec]);

    always_comb begin
        state_n           = state;
        vec_n             = vec;
        hold_cnt_n        = hold_cnt;
        err_count_n       = err_count;
        first_err_valid_n = first_err_valid;
        first_err_vec_n   = first_err_vec;
        busy_n            = busy;
        done_n            = done;
        pass_n            = pass;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n           = DRIVE;
                    vec_n             = 4'd0;
                    hold_cnt_n        = 8'd0;
                    err_count_n       = 5'd0;
                    first_err_valid_n = 1'b0;
                    first_err_vec_n   = 4'd0;
                    busy_n            = 1'b1;
                    done_n            = 1'b0;
                    pass_n            = 1'b0;
                end
            end
            DRIVE: begin
                if (hold_cnt == HOLD_LAST) begin
                    // Responses only matter on the last cycle of each hold window.
                    if (mismatch) begin
                        if (err_count != 5'd16)
                            err_count_n = err_count + 5'd1;
                        if (!first_err_valid) begin
                            first_err_valid_n = 1'b1;
                            first_err_vec_n   = vec;
                        end
                    end
                    hold_cnt_n = 8'd0;
                    vec_n      = vec + 4'd1;
                    if (vec == 4'd15) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_count_n == 5'd0);
                    end
                end else begin
                    hold_cnt_n = hold_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            vec             <= 4'd0;
            hold_cnt        <= 8'd0;
            err_count       <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            state           <= state_n;
            vec             <= vec_n;
            hold_cnt        <= hold_cnt_n;
            err_count       <= err_count_n;
            first_err_valid <= first_err_valid_n;
            first_err_vec   <= first_err_vec_n;
            busy            <= busy_n;
            done            <= done_n;
            pass            <= pass_n;
        end
    end

endmodule

// File: tb/tb_stim_resp_checker.sv
// tb/tb_stim_resp_checker.sv - directed self-checking bench for stim_resp_checker
module tb_stim_resp_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int evals = 0;
    int fails = 0;
    int mode  = 0;

    // Main instance, HOLD_CYCLES = 4
    logic       start_m = 1'b0;
    logic       f_m, g_m;
    logic       a_m, b_m, c_m, d_m, busy_m, done_m, pass_m, fev_valid_m;
    logic [4:0] err_m;
    logic [3:0] fev_m;
    logic [3:0] vec_m;
    logic [1:0] phase;

    // Boundary instances, HOLD_CYCLES = 2 and 255
    logic       start_b = 1'b0;
    logic       a_2, b_2, c_2, d_2, busy_2, done_2, pass_2, fev_valid_2;
    logic [4:0] err_2;
    logic [3:0] fev_2;
    logic       a_x, b_x, c_x, d_x, busy_x, done_x, pass_x, fev_valid_x;
    logic [4:0] err_x;
    logic [3:0] fev_x;

    assign vec_m = {a_m, b_m, c_m, d_m};

    // Mirrors the hold counter so glitches can be confined to non-sample cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !busy_m) phase <= 2'd0;
        else                   phase <= phase + 2'd1;
    end

    always_comb begin
        f_m = ^vec_m;
        g_m = &vec_m;
        if (mode == 1) g_m = 1'b0;
        if (mode == 2) f_m = ~f_m;
        if (mode == 3) begin
            if (vec_m == 4'd3 || vec_m == 4'd9) f_m = ~f_m;
            if (busy_m && phase != 2'd3)        f_m = ~f_m;
        end
    end

    stim_resp_checker #(.HOLD_CYCLES(4), .EXP_F(16'h6996), .EXP_G(16'h8000)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_m), .dut_f(f_m), .dut_g(g_m),
        .a(a_m), .b(b_m), .c(c_m), .d(d_m), .busy(busy_m), .done(done_m), .pass(pass_m),
        .err_count(err_m), .first_err_valid(fev_valid_m), .first_err_vec(fev_m)
    );

    stim_resp_checker #(.HOLD_CYCLES(2), .EXP_F(16'h6996), .EXP_G(16'h8000)) u_dut_h2 (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .dut_f(a_2 ^ b_2 ^ c_2 ^ d_2), .dut_g(a_2 & b_2 & c_2 & d_2),
        .a(a_2), .b(b_2), .c(c_2), .d(d_2), .busy(busy_2), .done(done_2), .pass(pass_2),
        .err_count(err_2), .first_err_valid(fev_valid_2), .first_err_vec(fev_2)
    );

    stim_resp_checker #(.HOLD_CYCLES(255), .EXP_F(16'h6996), .EXP_G(16'h8000)) u_dut_h255 (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .dut_f(a_x ^ b_x ^ c_x ^ d_x), .dut_g(a_x & b_x & c_x & d_x),
        .a(a_x), .b(b_x), .c(c_x), .d(d_x), .busy(busy_x), .done(done_x), .pass(pass_x),
        .err_count(err_x), .first_err_valid(fev_valid_x), .first_err_vec(fev_x)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {vec_m, busy_m, done_m, pass_m, err_m, fev_valid_m, fev_m}, 32'd0);
    endtask

    task automatic sweep(input string tag, input int mode_sel, input int extra_start_at,
                         input logic [4:0] e_err, input logic e_valid,
                         input logic [3:0] e_fev, input logic e_pass);
        int vec_errs;
        int done_at;
        logic [10:0] snap;
        mode = mode_sel;
        @(posedge clk); #1 start_m = 1'b1;
        @(posedge clk); #1 start_m = 1'b0;
        check({tag, "_start_busy"}, {busy_m, done_m, pass_m, vec_m, err_m}, {3'b100, 4'd0, 5'd0});
        vec_errs = 0;
        done_at  = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            start_m = (i == extra_start_at);
            if (i < 64 && vec_m != 4'(i / 4)) vec_errs++;
            if (done_m && done_at == 0) done_at = i;
        end
        start_m = 1'b0;
        check({tag, "_vec_order"}, vec_errs, 0);
        check({tag, "_done_cycle"}, done_at, 64);
        check({tag, "_busy_done"}, {busy_m, done_m, vec_m}, {1'b0, 1'b1, 4'd0});
        check({tag, "_err_count"}, err_m, e_err);
        check({tag, "_first_err"}, {fev_valid_m, fev_m}, {e_valid, e_fev});
        check({tag, "_pass"}, pass_m, e_pass);
        snap = {done_m, pass_m, err_m, fev_valid_m, fev_m[2:0]};
        repeat (3) @(posedge clk);
        #1 check({tag, "_done_stable"}, {done_m, pass_m, err_m, fev_valid_m, fev_m[2:0], fev_m[3]},
                 {snap, e_fev[3]});
    endtask

    initial begin
        int d2_at, dx_at, hold2, holdx;
        #1 check_all_zero("reset_state");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 check_all_zero("idle_after_reset");

        sweep("good",    0, 0, 5'd0,  1'b0, 4'd0,  1'b1);
        sweep("g_stuck", 1, 0, 5'd1,  1'b1, 4'd15, 1'b0);
        sweep("f_inv",   2, 0, 5'd16, 1'b1, 4'd0,  1'b0);
        sweep("glitch",  3, 0, 5'd2,  1'b1, 4'd3,  1'b0);

        // Reset in the middle of vector 7
        mode = 0;
        @(posedge clk); #1 start_m = 1'b1;
        @(posedge clk); #1 start_m = 1'b0;
        repeat (30) @(posedge clk);
        #1 check("pre_reset_vec", vec_m, 4'd7);
        rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all_zero("no_resume_after_reset");
        sweep("restart_ignored", 0, 10, 5'd0, 1'b0, 4'd0, 1'b1);

        // Boundary hold lengths
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        d2_at = 0; dx_at = 0; hold2 = 0; holdx = 0;
        for (int i = 1; i <= 5000; i++) begin
            @(posedge clk); #1;
            if (busy_2 && {a_2, b_2, c_2, d_2} == 4'd5) hold2++;
            if (busy_x && {a_x, b_x, c_x, d_x} == 4'd5) holdx++;
            if (done_2 && d2_at == 0) d2_at = i;
            if (done_x && dx_at == 0) dx_at = i;
            if (dx_at != 0) break;
        end
        check("h2_done_cycle", d2_at, 32);
        check("h2_hold", hold2, 2);
        check("h2_result", {pass_2, err_2, fev_valid_2}, {1'b1, 5'd0, 1'b0});
        check("h255_done_cycle", dx_at, 4080);
        check("h255_hold", holdx, 255);
        check("h255_result", {pass_x, err_x, fev_valid_x}, {1'b1, 5'd0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

endmodule
